// File: rtl/ppe_pkg.sv
// Shared definitions for the ppe_* family: default sizing, index width
// derivation and the mod-N pointer increment.
package ppe_pkg;

  localparam int PPE_N_DEFAULT       = 512;
  localparam int PPE_PTR_RST_DEFAULT = 0;

  // Width of an index/pointer field for n requesters; never narrower than 1 bit.
  function automatic int ppe_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Next index after idx in a ring of n entries (n-1 wraps to 0).
  function automatic int unsigned ppe_inc_mod(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ppe_search.sv
// Programmable priority encoder: finds the first set request bit at or after
// i_ptr, wrapping to index 0. Built from two simple lowest-bit encoders, one
// over the requests masked to i_ptr and above, one over all requests.
module ppe_search
  import ppe_pkg::*;
#(
  parameter int N = PPE_N_DEFAULT,
  parameter int W = ppe_idx_width(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_winner,
  output logic         o_found
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_masked;
  logic [W-1:0] w_masked_idx;
  logic [W-1:0] w_plain_idx;
  logic         w_masked_found;

  // Thermometer mask: bits below the pointer are excluded from the first pass.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i >= int'(i_ptr));
    end
  end

  assign w_masked       = i_req & w_mask;
  assign w_masked_found = |w_masked;

  // Two lowest-set-bit encoders; scanning downward lets the lowest index win.
  always_comb begin
    w_masked_idx = '0;
    w_plain_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_masked[i]) w_masked_idx = W'(i);
      if (i_req[i])    w_plain_idx  = W'(i);
    end
  end

  // A hit at or above the pointer takes precedence; otherwise the search wraps.
  assign o_winner = w_masked_found ? w_masked_idx : w_plain_idx;
  assign o_found  = |i_req;

endmodule

// File: rtl/ppe_rr_arbiter.sv
// Registered round-robin arbiter. Grants one requester at a time over a
// valid/ready handshake and rotates priority past each accepted winner.
module ppe_rr_arbiter
  import ppe_pkg::*;
#(
  parameter int N       = PPE_N_DEFAULT,
  parameter int W       = ppe_idx_width(N),
  parameter int PTR_RST = PPE_PTR_RST_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  output logic         o_gnt_valid,
  output logic [W-1:0] o_gnt_idx,
  output logic [N-1:0] o_gnt_onehot,
  input  logic         i_gnt_ready,
  input  logic         i_ptr_load,
  input  logic [W-1:0] i_ptr_val,
  output logic [W-1:0] o_ptr
);

  logic         r_gnt_valid;
  logic [W-1:0] r_gnt_idx;
  logic [N-1:0] r_gnt_onehot;
  logic [W-1:0] r_ptr;

  logic         w_accept;
  logic         w_hold;
  logic [W-1:0] w_ptr_eff;
  logic [W-1:0] w_winner;
  logic         w_found;
  logic [N-1:0] w_one;

  assign w_accept = r_gnt_valid & i_gnt_ready;
  assign w_hold   = r_gnt_valid & ~i_gnt_ready;
  assign w_one    = {{(N-1){1'b0}}, 1'b1};

  // Effective pointer: an explicit load beats the post-accept advance.
  always_comb begin
    w_ptr_eff = r_ptr;
    if (i_ptr_load) begin
      w_ptr_eff = i_ptr_val;
    end else if (w_accept) begin
      w_ptr_eff = W'(ppe_inc_mod(32'(r_gnt_idx), N));
    end
  end

  ppe_search #(
    .N (N),
    .W (W)
  ) u_search (
    .i_req    (i_req),
    .i_ptr    (w_ptr_eff),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  // Pointer and grant registers; a stalled grant is frozen until accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr        <= W'(PTR_RST);
      r_gnt_valid  <= 1'b0;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
    end else begin
      r_ptr <= w_ptr_eff;
      if (!w_hold) begin
        r_gnt_valid  <= w_found;
        r_gnt_idx    <= w_found ? w_winner : '0;
        r_gnt_onehot <= w_found ? (w_one << w_winner) : '0;
      end
    end
  end

  assign o_gnt_valid  = r_gnt_valid;
  assign o_gnt_idx    = r_gnt_idx;
  assign o_gnt_onehot = r_gnt_onehot;
  assign o_ptr        = r_ptr;

endmodule

// File: tb/tb_ppe_rr_arbiter.sv
// Directed self-checking bench for ppe_rr_arbiter with N=8, PTR_RST=0.
module tb_ppe_rr_arbiter;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         gntValid;
  logic [W-1:0] gntIdx;
  logic [N-1:0] gntOnehot;
  logic         gntReady;
  logic         ptrLoad;
  logic [W-1:0] ptrVal;
  logic [W-1:0] ptr;

  int compareCount  = 0;
  int mismatchCount = 0;

  ppe_rr_arbiter #(
    .N       (N),
    .W       (W),
    .PTR_RST (0)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .o_gnt_valid  (gntValid),
    .o_gnt_idx    (gntIdx),
    .o_gnt_onehot (gntOnehot),
    .i_gnt_ready  (gntReady),
    .i_ptr_load   (ptrLoad),
    .i_ptr_val    (ptrVal),
    .o_ptr        (ptr)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [N-1:0] rq, input logic rdy,
                               input logic ld, input logic [W-1:0] val);
    rst      = r;
    req      = rq;
    gntReady = rdy;
    ptrLoad  = ld;
    ptrVal   = val;
    @(posedge clk);
    #1;
  endtask

  task automatic expectGrant(input string tag, input logic v, input logic [W-1:0] idx,
                             input logic [W-1:0] p);
    logic [N-1:0] oh;
    oh = v ? (N'(1) << idx) : '0;
    checkOutput({tag, ".valid"},  32'(gntValid),  32'(v));
    checkOutput({tag, ".idx"},    32'(gntIdx),    32'(v ? idx : 3'd0));
    checkOutput({tag, ".onehot"}, 32'(gntOnehot), 32'(oh));
    checkOutput({tag, ".ptr"},    32'(ptr),       32'(p));
  endtask

  initial begin
    rst = 1'b1; req = '0; gntReady = 1'b0; ptrLoad = 1'b0; ptrVal = '0;

    // Reset state.
    applyStimulus(1, 8'h00, 0, 0, 0);
    applyStimulus(1, 8'h00, 0, 0, 0);
    expectGrant("reset", 0, 0, 0);

    // Full request, ready high: 0,1,...,7,0 with ptr following the winner.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, 8'hFF, 1, 0, 0);
      expectGrant($sformatf("full%0d", k), 1, W'(k % 8), W'(k % 8));
    end

    // Wrap: load 6 while accepting 0, sparse requests {0,2}.
    applyStimulus(0, 8'h05, 1, 1, 3'd6);
    expectGrant("wrap0", 1, 0, 6);
    applyStimulus(0, 8'h05, 1, 0, 0);
    expectGrant("wrap1", 1, 2, 1);
    applyStimulus(0, 8'h05, 1, 0, 0);
    expectGrant("wrap2", 1, 0, 3);
    applyStimulus(0, 8'h05, 1, 0, 0);
    expectGrant("wrap3", 1, 2, 1);

    // Hold: present idx 3, stall 4 cycles while req moves to bit 7.
    applyStimulus(0, 8'h08, 1, 0, 0);
    expectGrant("hold_setup", 1, 3, 3);
    applyStimulus(0, 8'h80, 0, 0, 0);
    expectGrant("hold1", 1, 3, 3);
    applyStimulus(0, 8'h80, 0, 1, 3'd5);
    expectGrant("hold2_load", 1, 3, 5);
    applyStimulus(0, 8'h80, 0, 0, 0);
    expectGrant("hold3", 1, 3, 5);
    applyStimulus(0, 8'h80, 0, 0, 0);
    expectGrant("hold4", 1, 3, 5);
    applyStimulus(0, 8'h80, 1, 0, 0);
    expectGrant("hold_accept", 1, 7, 4);
    applyStimulus(0, 8'h80, 1, 0, 0);
    expectGrant("wrap_last", 1, 7, 0);

    // Sole requester 4 is re-granted every cycle.
    applyStimulus(0, 8'h10, 1, 0, 0);
    expectGrant("sole0", 1, 4, 0);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(0, 8'h10, 1, 0, 0);
      expectGrant($sformatf("sole%0d", k), 1, 4, 5);
    end

    // Load concurrent with accept of idx 2: the load wins.
    applyStimulus(0, 8'h04, 1, 0, 0);
    expectGrant("load_setup", 1, 2, 5);
    applyStimulus(0, 8'hFF, 1, 1, 3'd6);
    expectGrant("load_win", 1, 6, 6);
    applyStimulus(0, 8'hFF, 1, 0, 0);
    expectGrant("load_next", 1, 7, 7);

    // Reset while a grant is stalled.
    applyStimulus(0, 8'hFF, 0, 0, 0);
    expectGrant("prerst_hold", 1, 7, 7);
    applyStimulus(1, 8'hFF, 0, 0, 0);
    expectGrant("midrst", 0, 0, 0);
    applyStimulus(0, 8'h00, 1, 0, 0);
    expectGrant("postrst_idle", 0, 0, 0);
    applyStimulus(0, 8'h60, 0, 0, 0);
    expectGrant("postrst_grant", 1, 5, 0);
    applyStimulus(0, 8'h00, 1, 0, 0);
    expectGrant("drain", 0, 0, 6);
    applyStimulus(0, 8'h00, 1, 0, 0);
    expectGrant("idle", 0, 0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
